alu_exec_pipe: RTL and testbench

Pipelined, handshaked execution front-end for the 64-bit ALU datapath. It accepts operation requests over a valid/ready interface, computes AND/OR/ADD/SUB in a two-stage pipeline, and returns tagged results with zero and signed-overflow flags over a second valid/ready interface. It sits between the issue logic and writeback, so the ALU can run under backpressure with full one-op-per-cycle throughput.

---
 rtl/alu_exec_pipe.sv | 135 +++++++++++++
 tb/tb_alu_exec_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_pipe.sv
// Two-stage pipelined ALU (AND/OR/ADD/SUB) between valid/ready request and response channels.
// Results carry the request tag plus zero and signed-overflow flags; completed responses are counted.
module alu_exec_pipe #(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_ctrl,
   input  logic [DATA_WIDTH-1:0] req_A,
   input  logic [DATA_WIDTH-1:0] req_B,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_zero,
   output logic                  rsp_ovf,
   output logic [TAG_WIDTH-1:0]  rsp_tag,
   output logic [CNT_WIDTH-1:0]  op_count
);

   localparam int MSB = DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } op_e;

   logic                  r_s1_valid;
   op_e                   r_s1_op;
   logic [DATA_WIDTH-1:0] r_s1_a;
   logic [DATA_WIDTH-1:0] r_s1_b;
   logic [TAG_WIDTH-1:0]  r_s1_tag;

   logic                  r_s2_valid;
   logic [DATA_WIDTH-1:0] r_s2_data;
   logic                  r_s2_zero;
   logic                  r_s2_ovf;
   logic [TAG_WIDTH-1:0]  r_s2_tag;
   logic [CNT_WIDTH-1:0]  r_op_count;

   logic                  w_s1_adv;
   logic                  w_s2_adv;
   logic [DATA_WIDTH-1:0] w_result;
   logic                  w_ovf;
   logic                  w_zero;

   // A stage moves whenever its downstream neighbour is empty or moving, so a full
   // pipeline still accepts a new request in the same cycle the response drains.
   assign w_s2_adv  = !r_s2_valid || rsp_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign req_ready = w_s1_adv;

   // NOTE: non-blocking assignments so every stage samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= req_valid;
      end
   end

   // NOTE: S1 payload has no reset; it is only ever observed when r_s1_valid qualifies it.
   always_ff @(posedge clk) begin
      if (w_s1_adv && req_valid) begin
         r_s1_op  <= op_e'(req_ctrl);
         r_s1_a   <= req_A;
         r_s1_b   <= req_B;
         r_s1_tag <= req_tag;
      end
   end

   always_comb begin
      // NOTE: defaults first so no branch can leave a signal unassigned and infer a latch.
      w_result = '0;
      w_ovf    = 1'b0;
      case (r_s1_op)
         OP_AND: w_result = r_s1_a & r_s1_b;
         OP_OR:  w_result = r_s1_a | r_s1_b;
         OP_ADD: begin
            w_result = r_s1_a + r_s1_b;
            w_ovf    = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_result[MSB] != r_s1_a[MSB]);
         end
         OP_SUB: begin
            w_result = r_s1_a - r_s1_b;
            w_ovf    = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_result[MSB] != r_s1_a[MSB]);
         end
         default: begin
            w_result = '0;
            w_ovf    = 1'b0;
         end
      endcase
   end

   assign w_zero = (w_result == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_zero  <= 1'b0;
         r_s2_ovf   <= 1'b0;
         r_s2_tag   <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= w_result;
            r_s2_zero <= w_zero;
            r_s2_ovf  <= w_ovf;
            r_s2_tag  <= r_s1_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (r_s2_valid && rsp_ready) begin
         r_op_count <= r_op_count + CNT_WIDTH'(1);
      end
   end

   assign rsp_valid = r_s2_valid;
   assign rsp_data  = r_s2_data;
   assign rsp_zero  = r_s2_zero;
   assign rsp_ovf   = r_s2_ovf;
   assign rsp_tag   = r_s2_tag;
   assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: vector table for single ops and flags, plus hand-written
// stream, backpressure, mid-flight reset and counter-wrap sequences.
module tb_alu_exec_pipe;

   localparam int DW = 64;
   localparam int TW = 4;

   typedef struct {
      logic [1:0]    ctrl;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [TW-1:0] tag;
      logic [DW-1:0] exp_data;
      logic          exp_zero;
      logic          exp_ovf;
   } vec_t;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      int            cyc;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_ctrl = 2'b00;
   logic [DW-1:0] req_A = '0;
   logic [DW-1:0] req_B = '0;
   logic [TW-1:0] req_tag = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          rsp_zero;
   logic          rsp_ovf;
   logic [TW-1:0] rsp_tag;
   logic [31:0]   op_count;

   logic          req_ready4;
   logic          rsp_valid4;
   logic [DW-1:0] rsp_data4;
   logic          rsp_zero4;
   logic          rsp_ovf4;
   logic [TW-1:0] rsp_tag4;
   logic [3:0]    op_count4;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc_cnt  = 0;
   rsp_t q[$];

   alu_exec_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
      .req_A(req_A), .req_B(req_B), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_tag(rsp_tag),
      .op_count(op_count)
   );

   // Narrow-counter build driven in lockstep with the main instance.
   alu_exec_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready4), .req_ctrl(req_ctrl),
      .req_A(req_A), .req_B(req_B), .req_tag(req_tag),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
      .rsp_zero(rsp_zero4), .rsp_ovf(rsp_ovf4), .rsp_tag(rsp_tag4),
      .op_count(op_count4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready)
         q.push_back('{tag: rsp_tag, data: rsp_data, cyc: cyc_cnt});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Presents one request and holds it until accepted; returns just after the accepting edge.
   task automatic send(input logic [1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] t, output int waits);
      waits     = 0;
      req_valid = 1'b1;
      req_ctrl  = c;
      req_A     = a;
      req_B     = b;
      req_tag   = t;
      @(negedge clk);
      while (!req_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 50) check("accept_bound", 64'(waits), 64'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic reset_pulse();
      req_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t vecs[8];
      int   waits;
      int   k;
      int   stall_acc;

      vecs[0] = '{2'b00, 64'd223,    64'd132,    4'd1, 64'd132,    1'b0, 1'b0};
      vecs[1] = '{2'b01, 64'd4013,   64'd3022,   4'd2, 64'd4079,   1'b0, 1'b0};
      vecs[2] = '{2'b10, 64'd5555,   64'd4321,   4'd3, 64'd9876,   1'b0, 1'b0};
      vecs[3] = '{2'b11, 64'd999999, 64'd111111, 4'd4, 64'd888888, 1'b0, 1'b0};
      vecs[4] = '{2'b11, 64'd5,      64'd5,      4'd5, 64'd0,      1'b1, 1'b0};
      vecs[5] = '{2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd6, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[6] = '{2'b11, 64'd0,      64'd1,      4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[7] = '{2'b00, 64'hF0,     64'h0F,     4'd8, 64'd0,      1'b1, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data",  rsp_data,       64'd0);
      check("rst_rsp_zero",  64'(rsp_zero),  64'd0);
      check("rst_rsp_ovf",   64'(rsp_ovf),   64'd0);
      check("rst_rsp_tag",   64'(rsp_tag),   64'd0);
      check("rst_op_count",  64'(op_count),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd1);

      // Vector table: accept in cycle c, nothing in cycle c+1, result in cycle c+2
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].tag, waits);
         check($sformatf("v%0d_accept_wait", i), 64'(waits), 64'd0);
         @(negedge clk);
         check($sformatf("v%0d_valid_early", i), 64'(rsp_valid), 64'd0);
         @(negedge clk);
         check($sformatf("v%0d_valid", i), 64'(rsp_valid), 64'd1);
         check($sformatf("v%0d_data", i),  rsp_data, vecs[i].exp_data);
         check($sformatf("v%0d_zero", i),  64'(rsp_zero), 64'(vecs[i].exp_zero));
         check($sformatf("v%0d_ovf", i),   64'(rsp_ovf),  64'(vecs[i].exp_ovf));
         check($sformatf("v%0d_tag", i),   64'(rsp_tag),  64'(vecs[i].tag));
         @(posedge clk);
         #1;
      end
      check("tbl_op_count",  64'(op_count),  64'd8);
      check("tbl_op_count4", 64'(op_count4), 64'd8);

      // Back-to-back stream of 8 ADDs
      reset_pulse();
      q.delete();
      for (int i = 0; i < 8; i++) begin
         send(2'b10, DW'(i * 1000), DW'(i), TW'(i), waits);
         check($sformatf("stream_accept_wait%0d", i), 64'(waits), 64'd0);
      end
      for (int c = 0; c < 20 && q.size() < 8; c++) @(posedge clk);
      #1;
      check("stream_count", 64'(q.size()), 64'd8);
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         check($sformatf("stream_tag%0d", i),  64'(q[i].tag), 64'(i));
         check($sformatf("stream_data%0d", i), q[i].data, DW'(i * 1001));
         if (i > 0) check($sformatf("stream_gap%0d", i), 64'(q[i].cyc - q[i-1].cyc), 64'd1);
      end
      check("stream_op_count", 64'(op_count), 64'd8);

      // Backpressure: rsp_ready low for the first 5 cycles of a 6-op stream
      q.delete();
      k = 0;
      stall_acc = 0;
      for (int c = 0; c < 20; c++) begin
         rsp_ready = (c >= 5);
         req_valid = (k < 6);
         req_ctrl  = 2'b01;
         req_A     = DW'(k + 1) << 8;
         req_B     = DW'(k);
         req_tag   = TW'(8 + k);
         @(negedge clk);
         if (c >= 2 && c < 5) begin
            check($sformatf("bp_ready_low%0d", c), 64'(req_ready), 64'd0);
            check($sformatf("bp_hold_valid%0d", c), 64'(rsp_valid), 64'd1);
            check($sformatf("bp_hold_tag%0d", c), 64'(rsp_tag), 64'd8);
            check($sformatf("bp_hold_data%0d", c), rsp_data, 64'h100);
         end
         if (c == 5) check("bp_full_ready", 64'(req_ready), 64'd1);
         if (req_valid && req_ready) begin
            if (c < 5) stall_acc++;
            k++;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      check("bp_stall_accepts", 64'(stall_acc), 64'd2);
      check("bp_total_accepts", 64'(k), 64'd6);
      check("bp_rsp_count", 64'(q.size()), 64'd6);
      for (int i = 0; i < 6 && i < q.size(); i++) begin
         check($sformatf("bp_tag%0d", i),  64'(q[i].tag), 64'(8 + i));
         check($sformatf("bp_data%0d", i), q[i].data, (DW'(i + 1) << 8) | DW'(i));
      end

      // Asynchronous reset with two ops in flight
      send(2'b10, 64'd1, 64'd2, 4'd1, waits);
      send(2'b10, 64'd3, 64'd4, 4'd2, waits);
      check("mid_pre_valid", 64'(rsp_valid), 64'd1);
      check("mid_pre_cnt_zero", 64'(op_count == 0), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
      check("mid_rsp_data",  rsp_data, 64'd0);
      check("mid_op_count",  64'(op_count), 64'd0);
      check("mid_op_count4", 64'(op_count4), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("mid_no_ghost", 64'(q.size()), 64'd0);
      send(2'b10, 64'd10, 64'd20, 4'd5, waits);
      for (int c = 0; c < 10 && op_count != 1; c++) @(posedge clk);
      #1;
      check("mid_post_count", 64'(op_count), 64'd1);
      check("mid_post_rsps", 64'(q.size()), 64'd1);
      if (q.size() > 0) begin
         check("mid_post_data", q[0].data, 64'd30);
         check("mid_post_tag",  64'(q[0].tag), 64'd5);
      end

      // Counter wrap: 16 more completions -> 17 total, 4-bit counter reads 1
      for (int i = 0; i < 16; i++)
         send(2'b00, '1, DW'(i), TW'(i), waits);
      for (int c = 0; c < 20 && op_count != 17; c++) @(posedge clk);
      #1;
      check("wrap_op_count",  64'(op_count),  64'd17);
      check("wrap_op_count4", 64'(op_count4), 64'd1);
      check("wrap_rsps",      64'(q.size()),  64'd17);
      check("wrap_ready4",    64'(req_ready4), 64'd1);
      check("wrap_valid4",    64'(rsp_valid4), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
